// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: FSM encoding
// and the digit-count helper used to reject undersized DIGITS at elaboration.
package bcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Number of decimal digits needed for the largest magnitude the input can carry.
   function automatic int bcd_min_digits(input int width, input int is_signed);
      longint unsigned max_v;
      int              n;
      if (is_signed != 0)
         max_v = 64'd1 << (width - 1);
      else
         max_v = (64'd1 << width) - 64'd1;
      n = 1;
      while (max_v >= 64'd10) begin
         max_v = max_v / 64'd10;
         n     = n + 1;
      end
      return n;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
// Purely combinational; no carry leaves the digit.
module bcd_digit_adj (
   input  logic [3:0] digit_in,
   output logic [3:0] digit_out
);

   assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;

endmodule

// File: rtl/bcd_seq_conv.sv
// Bit-serial binary-to-BCD converter, BIN_W cycles per operand; result held in DONE
// until out_ready, new operands refused (in_ready=0) while converting or holding.
module bcd_seq_conv
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3,
   parameter int SIGNED = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  sign_out,
   output logic                  busy
);

   localparam int CNT_W = $clog2(BIN_W);
   localparam int BCD_W = 4 * DIGITS;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

   generate
      if (BIN_W < 2) begin : g_bad_width
         $error("bcd_seq_conv: BIN_W must be at least 2");
      end
      if (DIGITS < bcd_min_digits(BIN_W, SIGNED)) begin : g_bad_digits
         $error("bcd_seq_conv: DIGITS too small for BIN_W/SIGNED");
      end
   endgenerate

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [BIN_W-1:0]        bin_q, bin_d;
   logic [BCD_W-1:0]        work_q, work_d;
   logic                    neg_q, neg_d;
   logic [BCD_W-1:0]        bcd_out_q, bcd_out_d;
   logic                    sign_out_q, sign_out_d;
   logic                    in_ready_q, in_ready_d;
   logic                    out_valid_q, out_valid_d;
   logic                    busy_q, busy_d;

   logic [BCD_W-1:0]        bcd_adj;
   logic [BCD_W+BIN_W-1:0]  shift_v;
   logic [BIN_W-1:0]        load_mag;
   logic                    load_neg;

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_adj
         bcd_digit_adj u_adj (
            .digit_in  (work_q[4*g +: 4]),
            .digit_out (bcd_adj[4*g +: 4])
         );
      end
   endgenerate

   assign shift_v = {bcd_adj, bin_q} << 1;

   // Two's complement minimum negates to itself, which is exactly the unsigned magnitude.
   always_comb begin
      load_mag = bin_in;
      load_neg = 1'b0;
      if ((SIGNED != 0) && bin_in[BIN_W-1]) begin
         load_mag = -bin_in;
         load_neg = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      bin_d       = bin_q;
      work_d      = work_q;
      neg_d       = neg_q;
      bcd_out_d   = bcd_out_q;
      sign_out_d  = sign_out_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               bin_d      = load_mag;
               work_d     = '0;
               neg_d      = load_neg;
               count_d    = '0;
               state_d    = ST_CONV;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
            end
         end
         ST_CONV: begin
            work_d = shift_v[BCD_W+BIN_W-1:BIN_W];
            bin_d  = shift_v[BIN_W-1:0];
            if (count_q == LAST_CNT) begin
               state_d     = ST_DONE;
               busy_d      = 1'b0;
               out_valid_d = 1'b1;
               bcd_out_d   = shift_v[BCD_W+BIN_W-1:BIN_W];
               sign_out_d  = neg_q;
            end else begin
               count_d = count_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         bin_q       <= '0;
         work_q      <= '0;
         neg_q       <= 1'b0;
         bcd_out_q   <= '0;
         sign_out_q  <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         bin_q       <= bin_d;
         work_q      <= work_d;
         neg_q       <= neg_d;
         bcd_out_q   <= bcd_out_d;
         sign_out_q  <= sign_out_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign bcd_out   = bcd_out_q;
   assign sign_out  = sign_out_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Bench for bcd_seq_conv: three instances (8-bit unsigned, 8-bit signed, 16-bit unsigned)
// checked against an arithmetic decimal-digit model.
module tb_bcd_seq_conv;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] bin_in = '0;
   int          sel = 0;
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic        iv_u8, iv_s8, iv_u16;
   logic        ir_u8, ir_s8, ir_u16;
   logic        ov_u8, ov_s8, ov_u16;
   logic        sg_u8, sg_s8, sg_u16;
   logic        bz_u8, bz_s8, bz_u16;
   logic [11:0] bcd_u8, bcd_s8;
   logic [19:0] bcd_u16;

   assign iv_u8  = in_valid && (sel == 0);
   assign iv_s8  = in_valid && (sel == 1);
   assign iv_u16 = in_valid && (sel == 2);

   bcd_seq_conv #(.BIN_W(8), .DIGITS(3), .SIGNED(0)) dut_u8 (
      .clk(clk), .rst(rst), .in_valid(iv_u8), .in_ready(ir_u8), .bin_in(bin_in[7:0]),
      .out_valid(ov_u8), .out_ready(out_ready), .bcd_out(bcd_u8), .sign_out(sg_u8), .busy(bz_u8)
   );

   bcd_seq_conv #(.BIN_W(8), .DIGITS(3), .SIGNED(1)) dut_s8 (
      .clk(clk), .rst(rst), .in_valid(iv_s8), .in_ready(ir_s8), .bin_in(bin_in[7:0]),
      .out_valid(ov_s8), .out_ready(out_ready), .bcd_out(bcd_s8), .sign_out(sg_s8), .busy(bz_s8)
   );

   bcd_seq_conv #(.BIN_W(16), .DIGITS(5), .SIGNED(0)) dut_u16 (
      .clk(clk), .rst(rst), .in_valid(iv_u16), .in_ready(ir_u16), .bin_in(bin_in),
      .out_valid(ov_u16), .out_ready(out_ready), .bcd_out(bcd_u16), .sign_out(sg_u16), .busy(bz_u16)
   );

   logic        cur_in_ready, cur_out_valid, cur_sign, cur_busy;
   logic [19:0] cur_bcd;

   always_comb begin
      cur_in_ready  = ir_u8;
      cur_out_valid = ov_u8;
      cur_bcd       = {8'h00, bcd_u8};
      cur_sign      = sg_u8;
      cur_busy      = bz_u8;
      if (sel == 1) begin
         cur_in_ready  = ir_s8;
         cur_out_valid = ov_s8;
         cur_bcd       = {8'h00, bcd_s8};
         cur_sign      = sg_s8;
         cur_busy      = bz_s8;
      end else if (sel == 2) begin
         cur_in_ready  = ir_u16;
         cur_out_valid = ov_u16;
         cur_bcd       = bcd_u16;
         cur_sign      = sg_u16;
         cur_busy      = bz_u16;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: decimal digits of the value's magnitude by repeated division.
   function automatic logic [20:0] ref_conv(input int s, input logic [15:0] v);
      longint      m;
      logic [20:0] r;
      r = '0;
      if (s == 1) begin
         m = longint'($signed(v[7:0]));
         if (m < 0) begin
            r[20] = 1'b1;
            m     = -m;
         end
      end else if (s == 0) begin
         m = longint'(v[7:0]);
      end else begin
         m = longint'(v);
      end
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return r;
   endfunction

   function automatic int width_of(input int s);
      return (s == 2) ? 16 : 8;
   endfunction

   task automatic select(input int s);
      sel = s;
      #1;
   endtask

   // One operand with out_ready already high; ends one cycle after out_valid is seen.
   task automatic do_op(input int s, input logic [15:0] v, input logic [20:0] exp, input string tag);
      int n;
      select(s);
      chk({tag, "_in_ready"}, cur_in_ready, 1);
      bin_in   = v;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      bin_in   = 16'($urandom);
      n = 0;
      while (!cur_out_valid && n < 64) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_latency"}, n, width_of(s));
      chk({tag, "_bcd"}, cur_bcd, exp[19:0]);
      chk({tag, "_sign"}, cur_sign, exp[20]);
      @(negedge clk);
      chk({tag, "_valid_drop"}, cur_out_valid, 0);
   endtask

   typedef struct {
      int          s;
      logic [15:0] val;
      logic [19:0] bcd;
      logic        sign;
   } vec_t;

   vec_t vecs[8];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      int unsigned c0;
      logic        spurious;

      vecs[0] = '{0, 16'h00FF, 20'h00255, 1'b0};
      vecs[1] = '{0, 16'h0000, 20'h00000, 1'b0};
      vecs[2] = '{1, 16'h0080, 20'h00128, 1'b1};
      vecs[3] = '{1, 16'h00FF, 20'h00001, 1'b1};
      vecs[4] = '{1, 16'h007F, 20'h00127, 1'b0};
      vecs[5] = '{2, 16'hFFFF, 20'h65535, 1'b0};
      vecs[6] = '{2, 16'h0000, 20'h00000, 1'b0};
      vecs[7] = '{2, 16'd40960, 20'h40960, 1'b0};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int s = 0; s < 3; s++) begin
         select(s);
         chk("reset_in_ready", cur_in_ready, 1);
         chk("reset_out_valid", cur_out_valid, 0);
         chk("reset_busy", cur_busy, 0);
         chk("reset_bcd", cur_bcd, 0);
         chk("reset_sign", cur_sign, 0);
      end

      out_ready = 1'b1;
      foreach (vecs[i])
         do_op(vecs[i].s, vecs[i].val, {vecs[i].sign, vecs[i].bcd}, "table");

      // Exhaustive 8-bit unsigned sweep at full throughput.
      @(negedge clk);
      c0 = cyc;
      for (int v = 0; v < 256; v++)
         do_op(0, 16'(v), ref_conv(0, 16'(v)), "sweep");
      chk("sweep_cycles", cyc - c0, 2560);

      for (int k = 0; k < 150; k++) begin
         int          s;
         logic [15:0] v;
         s = $urandom_range(0, 2);
         v = (s == 2) ? 16'($urandom) : 16'($urandom_range(0, 255));
         do_op(s, v, ref_conv(s, v), "rand");
      end

      // Back-pressure: result held in DONE, fresh in_valid ignored.
      select(0);
      out_ready = 1'b0;
      bin_in    = 16'd173;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!cur_out_valid && n < 64) begin
         @(negedge clk);
         n++;
      end
      chk("bp_latency", n, 8);
      for (int k = 0; k < 20; k++) begin
         in_valid = 1'b1;
         bin_in   = 16'($urandom_range(0, 255));
         @(negedge clk);
         chk("bp_out_valid", cur_out_valid, 1);
         chk("bp_bcd", cur_bcd, 20'h00173);
         chk("bp_in_ready", cur_in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", cur_out_valid, 0);
      chk("bp_release_ready", cur_in_ready, 1);
      do_op(0, 16'd42, ref_conv(0, 16'd42), "bp_next");

      // Reset in the middle of a conversion.
      select(0);
      bin_in   = 16'h0099;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_busy_before", cur_busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_in_ready", cur_in_ready, 1);
      chk("abort_out_valid", cur_out_valid, 0);
      chk("abort_bcd", cur_bcd, 0);
      chk("abort_busy", cur_busy, 0);
      spurious = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (cur_out_valid) spurious = 1'b1;
      end
      chk("abort_no_spurious_valid", spurious, 0);
      do_op(0, 16'd99, ref_conv(0, 16'd99), "abort_next");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
